// File: rtl/bram_fpadd_core_if.sv
// bram_fpadd_core_if: RX burst in, valid/ready result stream out, sticky error
interface bram_fpadd_core_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic [19:0] numData;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready;
  logic        err;
  modport master (output data_in, valid_in, numData, ready, input data_out, valid_out, err);
  modport slave  (input data_in, valid_in, numData, ready, output data_out, valid_out, err);
endinterface

// File: rtl/bram_fpadd_core.sv
// bram_fpadd_core: buffers a burst into BRAM, streams out mem[i] + mem[N-1-i] in FP32
module bram_fpadd_core #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  bram_fpadd_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  localparam int CW = ADDR_W + 1;
  localparam int FW = $clog2(OFIFO_DEPTH);
  localparam logic [19:0] DEPTH = 20'(1 << ADDR_W);
  localparam logic [FW+1:0] FD = (FW+2)'(OFIFO_DEPTH);
  state_t state, state_d;
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] fifo [OFIFO_DEPTH];
  logic [DATA_W-1:0] q_a, q_b, sum_r;
  logic [CW-1:0] n, n_in, wr_cnt, rd_i, pop_cnt;
  logic [ADDR_W-1:0] waddr, rb;
  logic [FW-1:0] wp, rp;
  logic [FW:0] fcnt;
  logic [FW+1:0] in_use;
  logic wr_en, issue, err_set, pop, v1, v2, err;
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] a0, b0, x, y;
    logic [27:0] mx, my, s;
    logic [7:0] d;
    int p, e;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
    a0 = a[30:23] == 8'd0 ? {a[31], 31'd0} : a;
    b0 = b[30:23] == 8'd0 ? {b[31], 31'd0} : b;
    x = a0[30:0] >= b0[30:0] ? a0 : b0;
    y = a0[30:0] >= b0[30:0] ? b0 : a0;
    d = x[30:23] - y[30:23];
    mx = x[30:23] == 8'd0 ? '0 : {2'b01, x[22:0], 3'b000};
    my = (y[30:23] == 8'd0 || d >= 8'd26) ? '0 : {2'b01, y[22:0], 3'b000} >> d;
    s = x[31] == y[31] ? mx + my : mx - my;
    p = 0;
    for (int k = 0; k < 28; k++) if (s[k]) p = k;
    e = int'(x[30:23]) + p - 26;
    s = p == 27 ? s >> 1 : s << (26 - p);
    return s == '0 ? 32'd0 : e >= 255 ? {x[31], 8'hFF, 23'd0} : e <= 0 ? {x[31], 31'd0} : {x[31], 8'(e), s[25:3]};
  endfunction
  assign n_in = bus.numData > DEPTH ? CW'(DEPTH) : bus.numData[CW-1:0];
  assign rb = ADDR_W'(n - 1 - rd_i);
  assign in_use = (FW+2)'(fcnt) + (FW+2)'(v1) + (FW+2)'(v2);
  assign pop = bus.valid_out && bus.ready;
  assign bus.valid_out = fcnt != '0;
  assign bus.data_out = bus.valid_out ? fifo[rp] : '0;
  assign bus.err = err;
  always_comb begin
    state_d = state;
    wr_en = 1'b0;
    issue = 1'b0;
    err_set = 1'b0;
    waddr = state == IDLE ? '0 : wr_cnt[ADDR_W-1:0];
    case (state)
      IDLE: if (bus.valid_in) begin
        err_set = bus.numData == '0 || bus.numData > DEPTH;
        wr_en = bus.numData != '0;
        state_d = bus.numData == '0 ? IDLE : n_in == CW'(1) ? DRAIN : LOAD;
      end
      LOAD: if (bus.valid_in) begin
        wr_en = 1'b1;
        state_d = wr_cnt == n - 1 ? DRAIN : LOAD;
      end
      DRAIN: begin
        err_set = bus.valid_in;
        issue = rd_i != n && in_use < FD;
        state_d = pop_cnt == n ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      n <= '0;
      wr_cnt <= '0;
      rd_i <= '0;
      pop_cnt <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      n <= state == IDLE ? n_in : n;
      wr_cnt <= state == IDLE ? CW'(1) : wr_cnt + CW'(wr_en);
      rd_i <= state == IDLE ? '0 : rd_i + CW'(issue);
      pop_cnt <= state == IDLE ? '0 : pop_cnt + CW'(pop);
      v1 <= issue;
      v2 <= v1;
      wp <= wp + FW'(v2);
      rp <= rp + FW'(pop);
      fcnt <= fcnt + (FW+1)'(v2) - (FW+1)'(pop);
      err <= err | err_set;
    end
  end
  // storage and datapath carry no reset; validity is tracked by v1/v2/fcnt
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= bus.data_in;
    if (issue) begin
      q_a <= mem[rd_i[ADDR_W-1:0]];
      q_b <= mem[rb];
    end
    sum_r <= fp_add(q_a, q_b);
    if (v2) fifo[wp] <= sum_r;
  end
endmodule
